// File: rtl/mv_drain_if.sv
// mv_drain_if: output element stream of the drain engine.
// Ports: m_valid/m_data/m_last from the drain, m_ready from the consumer.
interface mv_drain_if #(parameter int RW = 8);
  logic m_valid;
  logic m_ready;
  logic [RW-1:0] m_data;
  logic m_last;
  modport master (output m_valid, m_data, m_last, input m_ready);
  modport slave (input m_valid, m_data, m_last, output m_ready);
endinterface

// File: rtl/mv_drain.sv
// mv_drain: reads N result words from a BRAM starting at base_addr and streams them out.
// Ports: clk; rst (async, active-low); start/base_addr run request; rd_en/rd_addr/rd_data BRAM
// read port (data one cycle after rd_en); m stream (valid/ready/data/last); busy; done pulse.
module mv_drain #(
  parameter int N = 4,
  parameter int RW = 8,
  parameter int BRAM_DEPTH = 32,
  localparam int AW = $clog2(BRAM_DEPTH),
  localparam int CW = $clog2(N) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [AW-1:0] base_addr,
  output logic rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [RW-1:0] rd_data,
  mv_drain_if.master m,
  output logic busy,
  output logic done
);
  typedef enum logic [1:0] {IDLE, READ, FLUSH} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [CW-1:0] iss_q, iss_d, dlv_q, dlv_d;
  logic pend_q, pend_d, wp_q, wp_d, rp_q, rp_d, done_q, done_d;
  logic [1:0] cnt_q, cnt_d, occ;
  logic [RW-1:0] fifo_q [2];
  logic [RW-1:0] fifo_d [2];
  logic hs, accept, last_rd;
  always_comb begin
    m.m_valid = cnt_q != 2'd0;
    m.m_data = fifo_q[rp_q];
    m.m_last = m.m_valid && dlv_q == CW'(N - 1);
    hs = m.m_valid && m.m_ready;
    accept = state_q == IDLE && start;
    // Reads in flight count against FIFO space so returning data always has a slot.
    occ = cnt_q + {1'b0, pend_q};
    rd_en = state_q == READ && (occ < 2'd2 || (occ == 2'd2 && hs));
    last_rd = rd_en && iss_q == CW'(N - 1);
    state_d = accept ? READ :
              (state_q == READ && last_rd) ? FLUSH :
              (state_q == FLUSH && hs && m.m_last) ? IDLE : state_q;
    rd_addr_d = accept ? base_addr :
                !rd_en ? rd_addr_q :
                rd_addr_q == AW'(BRAM_DEPTH - 1) ? '0 : rd_addr_q + AW'(1);
    iss_d = accept ? '0 : iss_q + CW'(rd_en);
    dlv_d = accept ? '0 : dlv_q + CW'(hs);
    pend_d = rd_en;
    wp_d = wp_q ^ pend_q;
    rp_d = rp_q ^ hs;
    cnt_d = cnt_q + {1'b0, pend_q} - {1'b0, hs};
    fifo_d = fifo_q;
    fifo_d[wp_q] = pend_q ? rd_data : fifo_q[wp_q];
    done_d = state_q == FLUSH && hs && m.m_last;
    busy = state_q != IDLE;
    done = done_q;
    rd_addr = rd_addr_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rd_addr_q <= '0;
      iss_q <= '0;
      dlv_q <= '0;
      pend_q <= 1'b0;
      wp_q <= 1'b0;
      rp_q <= 1'b0;
      cnt_q <= '0;
      done_q <= 1'b0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else begin
      state_q <= state_d;
      rd_addr_q <= rd_addr_d;
      iss_q <= iss_d;
      dlv_q <= dlv_d;
      pend_q <= pend_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
      fifo_q <= fifo_d;
    end
  end
endmodule

// File: tb/tb_mv_drain.sv
// tb_mv_drain: self-checking bench for mv_drain with a BRAM model and a run-level reference.
module tb_mv_drain;
  localparam int N = 4, RW = 8, D = 32;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic rd_en, busy, done;
  logic [4:0] base_addr = '0, rd_addr;
  logic [7:0] rd_data = '0;
  logic [7:0] mem [D];
  int checks = 0, errors = 0;
  mv_drain_if #(.RW(RW)) m_if();
  mv_drain #(.N(N), .RW(RW), .BRAM_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .m(m_if), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];
  typedef struct {
    logic st;
    logic e_rd;
    logic [4:0] e_addr;
    logic e_v;
    logic [7:0] e_d;
    logic e_last;
    logic e_busy;
    logic e_done;
  } vec_t;
  vec_t tv [9];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask
  // One run from base b; expected stream is mem[b..b+N-1] modulo depth, in order, once.
  task automatic run(input logic [4:0] b, input bit rnd, input bit mid);
    logic [7:0] got [$];
    logic [4:0] adr [$];
    int nd = 0, stray = 0, unstable = 0;
    bit held = 0, fin = 0;
    logic [7:0] hd = '0;
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = b;
    m_if.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int c = 0; c < 200 && !fin; c++) begin
      @(negedge clk);
      if (rd_en) adr.push_back(rd_addr);
      if (m_if.m_valid) begin
        if (held && m_if.m_data !== hd) unstable++;
        if (m_if.m_last != (got.size() == N - 1)) stray++;
        if (m_if.m_ready) got.push_back(m_if.m_data);
      end
      held = m_if.m_valid && !m_if.m_ready;
      hd = m_if.m_data;
      if (done) begin
        nd++;
        fin = 1;
      end
      @(posedge clk); #1;
      start = mid && busy;
      base_addr = 5'($urandom);
      m_if.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    chk("run_timeout", 32'(fin), 1);
    chk("run_count", got.size(), N);
    for (int i = 0; i < got.size() && i < N; i++) chk("run_data", got[i], mem[(b + i) % D]);
    chk("run_reads", adr.size(), N);
    for (int i = 0; i < adr.size() && i < N; i++) chk("run_addr", adr[i], (b + i) % D);
    chk("run_last", stray, 0);
    chk("run_stable", unstable, 0);
    chk("run_done", nd, 1);
    chk("run_busy_end", busy, 0);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("run_idle", {rd_en, m_if.m_valid, done}, 0);
      @(posedge clk); #1;
    end
  endtask
  initial begin
    logic [7:0] got [$];
    int rdn;
    bit fin;
    for (int i = 0; i < D; i++) mem[i] = 8'(i + 10);
    tv[0] = '{1, 0, 0, 0, 0, 0, 0, 0};
    tv[1] = '{0, 1, 0, 0, 0, 0, 1, 0};
    tv[2] = '{0, 1, 1, 0, 0, 0, 1, 0};
    tv[3] = '{0, 1, 2, 1, 10, 0, 1, 0};
    tv[4] = '{0, 1, 3, 1, 11, 0, 1, 0};
    tv[5] = '{0, 0, 4, 1, 12, 0, 1, 0};
    tv[6] = '{0, 0, 4, 1, 13, 1, 1, 0};
    tv[7] = '{0, 0, 4, 0, 0, 0, 0, 1};
    tv[8] = '{0, 0, 4, 0, 0, 0, 0, 0};
    m_if.m_ready = 1'b0;
    #3;
    chk("reset_outs", {rd_en, m_if.m_valid, m_if.m_last, busy, done}, 0);
    chk("reset_addr", rd_addr, 0);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      rst = 1'b1;
      start = tv[i].st;
      base_addr = '0;
      m_if.m_ready = 1'b1;
      @(negedge clk);
      chk("tv_rd_en", rd_en, tv[i].e_rd);
      chk("tv_rd_addr", rd_addr, tv[i].e_addr);
      chk("tv_valid", m_if.m_valid, tv[i].e_v);
      if (tv[i].e_v) chk("tv_data", m_if.m_data, tv[i].e_d);
      chk("tv_last", m_if.m_last, tv[i].e_last);
      chk("tv_busy", busy, tv[i].e_busy);
      chk("tv_done", done, tv[i].e_done);
    end
    run(5'd30, 0, 0);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = '0;
    m_if.m_ready = 1'b0;
    rdn = 0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      rdn += int'(rd_en);
      if (c >= 3) begin
        chk("stall_valid", m_if.m_valid, 1);
        chk("stall_data", m_if.m_data, 10);
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("stall_reads", 32'(rdn <= 2), 1);
    m_if.m_ready = 1'b1;
    fin = 0;
    for (int c = 0; c < 20 && !fin; c++) begin
      @(negedge clk);
      if (m_if.m_valid && m_if.m_ready) got.push_back(m_if.m_data);
      if (done) fin = 1;
      @(posedge clk); #1;
    end
    chk("stall_done", 32'(fin), 1);
    chk("stall_count", got.size(), N);
    for (int i = 0; i < got.size() && i < N; i++) chk("stall_order", got[i], 10 + i);
    run(5'd5, 0, 1);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = '0;
    m_if.m_ready = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("prerst_valid", m_if.m_valid, 1);
    rst = 1'b0;
    #1;
    chk("rst_outs", {rd_en, m_if.m_valid, m_if.m_last, busy, done}, 0);
    chk("rst_addr", rd_addr, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post_rst_idle", {rd_en, m_if.m_valid, done, busy}, 0);
      @(posedge clk); #1;
    end
    run(5'd12, 0, 0);
    for (int r = 0; r < 100; r++) run(5'($urandom), 1, r[0]);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
